// File: rtl/alu_arbiter_if.sv
// Operation encoding shared by the arbiter, its requesters and the external ALU, plus the
// bundle that carries every handshake and ALU signal of alu_arbiter.
//
// controls_pkg
//   alu_op      3-bit ALU operation; OpAdd is the all-zero reset encoding
//
// alu_arbiter_if #(BUS_WIDTH)
//   req_valid   [1:0] per-requester request valid
//   req_ready   [1:0] per-requester accept, one-hot or zero
//   req_op0/1   requested operation
//   req_a0/b0, req_a1/b1   signed operands per requester
//   rsp_valid/rsp_ready    result handshake
//   rsp_id, rsp_out, rsp_zero, rsp_neg   registered result, flags and issuing requester
//   alu_a, alu_b, alu_sel  operands and operation presented to the ALU
//   alu_out, alu_zero, alu_neg   ALU result and flags
//   busy        arbiter is not idle
// Modports: slave = the arbiter; master = requesters, consumer and ALU together.

package controls_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpSlt = 3'd5,
    OpSll = 3'd6,
    OpMul = 3'd7
  } alu_op;

endpackage

interface alu_arbiter_if #(
  parameter int unsigned BUS_WIDTH = 32
);
  import controls_pkg::*;

  logic        [1:0]           req_valid;
  logic        [1:0]           req_ready;
  alu_op                       req_op0;
  alu_op                       req_op1;
  logic signed [BUS_WIDTH-1:0] req_a0;
  logic signed [BUS_WIDTH-1:0] req_b0;
  logic signed [BUS_WIDTH-1:0] req_a1;
  logic signed [BUS_WIDTH-1:0] req_b1;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_id;
  logic        [BUS_WIDTH-1:0] rsp_out;
  logic                        rsp_zero;
  logic                        rsp_neg;

  logic signed [BUS_WIDTH-1:0] alu_a;
  logic signed [BUS_WIDTH-1:0] alu_b;
  alu_op                       alu_sel;
  logic        [BUS_WIDTH-1:0] alu_out;
  logic                        alu_zero;
  logic                        alu_neg;

  logic                        busy;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output req_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_neg,
    input  rsp_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_zero, alu_neg,
    output busy
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_neg,
    output rsp_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_zero, alu_neg,
    input  busy
  );

endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (0 = execute stage,
// 1 = address/branch unit). A granted request is latched onto the ALU inputs, held for one
// cycle (MUL_LAT cycles for OpMul), then the ALU result, flags and requester id are
// registered and held until the consumer takes them.
//
// Parameters
//   BUS_WIDTH  operand/result width
//   MUL_LAT    cycles the ALU inputs are held for OpMul before capture (>= 1)
//   CNT_W      latency counter width (derived)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   bus        alu_arbiter_if.slave: request, response and ALU signals
//
// Build option
//   ALU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie; otherwise ties are
//                          resolved round-robin against the last served requester.

module alu_arbiter
  import controls_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned CNT_W     = $clog2(MUL_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    bus
);

  if (MUL_LAT < 1) begin : g_bad_lat
    $error("alu_arbiter: MUL_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic        [CNT_W-1:0]     cnt_q, cnt_d;
  logic                        last_grant_q, last_grant_d;

  logic signed [BUS_WIDTH-1:0] alu_a_q, alu_a_d;
  logic signed [BUS_WIDTH-1:0] alu_b_q, alu_b_d;
  alu_op                       alu_sel_q, alu_sel_d;

  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_id_q, rsp_id_d;
  logic        [BUS_WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic                        rsp_zero_q, rsp_zero_d;
  logic                        rsp_neg_q, rsp_neg_d;

  logic                        any_valid;
  logic                        gnt;
  alu_op                       gnt_op;
  logic        [1:0]           req_ready;

  // Grant choice, meaningful only when any_valid is set.
  always_comb begin
    any_valid = |bus.req_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt = ~bus.req_valid[0];
`else
    // On a tie serve whoever was not served last; otherwise the lone valid requester.
    gnt = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
`endif
    gnt_op = gnt ? bus.req_op1 : bus.req_op0;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_neg_d    = rsp_neg_q;
    req_ready    = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready[gnt] = 1'b1;
          alu_a_d        = gnt ? bus.req_a1 : bus.req_a0;
          alu_b_d        = gnt ? bus.req_b1 : bus.req_b0;
          alu_sel_d      = gnt_op;
          rsp_id_d       = gnt;
          cnt_d          = (gnt_op == OpMul) ? CNT_W'(MUL_LAT - 1) : '0;
          state_d        = StExec;
        end
      end

      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_out_d   = bus.alu_out;
          rsp_zero_d  = bus.alu_zero;
          rsp_neg_d   = bus.alu_neg;
          rsp_valid_d = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = rsp_id_q;
`endif
          state_d     = StResp;
        end
      end

      StResp: begin
        // rsp_out and flags keep their value after the handshake.
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= OpAdd;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_neg_q    <= rsp_neg_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_neg   = rsp_neg_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
